// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM encoding and state decode helpers for the instruction-memory loader.
package imem_loader_pkg;

   localparam int         IMEM_ADDR_W   = 8;
   localparam int         IMEM_DATA_W   = 16;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE, ST_CNT, ST_BASE, ST_HI, ST_LO, ST_CHK,
      ST_ARM, ST_START, ST_RUN, ST_ERR
   } state_t;

   function automatic logic st_busy(state_t s);
      return s inside {ST_CNT, ST_BASE, ST_HI, ST_LO, ST_CHK, ST_ARM, ST_START};
   endfunction

   // The CPU hand-off states are the only ones that refuse bytes.
   function automatic logic st_ready(state_t s);
      return !(s inside {ST_ARM, ST_START});
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              i_we;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_wdata;

   modport master (input rx_data, rx_valid, output rx_ready, i_we, i_addr, i_wdata);
   modport slave  (output rx_data, rx_valid, input rx_ready, i_we, i_addr, i_wdata);
endinterface

// File: rtl/imem_loader_chk.sv
// Running XOR checksum: clear, accumulate a byte, compare against a received value.
module imem_loader_chk (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       acc,
   input  logic [7:0] din,
   input  logic [7:0] cmp,
   output logic       match
);
   logic [7:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr)      sum_d = 8'h00;
      else if (acc) sum_d = sum_q ^ din;
   end

   always_ff @(posedge clk) begin
      if (rst) sum_q <= 8'h00;
      else     sum_q <= sum_d;
   end

   assign match = (sum_q == cmp);
endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction-memory loader; holds the CPU off while loading, then enables and starts it.
// Define IMEM_LOADER_BASE_ADDR_EN to take a BASE start-address byte after CNT.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_W    = IMEM_ADDR_W,
   parameter int         DATA_W    = IMEM_DATA_W,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         START_DLY = 1
) (
   input  logic           clk,
   input  logic           rst,
   imem_loader_if.master  bus,
   output logic           cpu_enable,
   output logic           cpu_start,
   output logic           busy,
   output logic           done,
   output logic           err
);
   state_t            state_q, state_d;
   logic [8:0]        count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        hi_q, hi_d;
   logic [3:0]        dly_q, dly_d;
   logic              i_we_q, i_we_d;
   logic [ADDR_W-1:0] i_addr_q, i_addr_d;
   logic [DATA_W-1:0] i_wdata_q, i_wdata_d;
   logic              cpu_enable_q, cpu_enable_d;
   logic              cpu_start_q, cpu_start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              rx_rdy, xfer, chk_clr, chk_acc, chk_match;

   assign rx_rdy = st_ready(state_q);
   assign xfer   = bus.rx_valid && rx_rdy;

   imem_loader_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .clr   (chk_clr),
      .acc   (chk_acc),
      .din   (bus.rx_data),
      .cmp   (bus.rx_data),
      .match (chk_match)
   );

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      addr_d       = addr_q;
      hi_d         = hi_q;
      dly_d        = dly_q;
      i_we_d       = 1'b0;
      i_addr_d     = i_addr_q;
      i_wdata_d    = i_wdata_q;
      cpu_enable_d = cpu_enable_q;
      cpu_start_d  = 1'b0;
      done_d       = done_q;
      err_d        = err_q;
      chk_clr      = 1'b0;
      chk_acc      = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN, ST_ERR: if (xfer && bus.rx_data == SYNC_BYTE) begin
            chk_clr = 1'b1;
            state_d = ST_CNT;
         end
         ST_CNT: if (xfer) begin
            count_d      = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
            chk_acc      = 1'b1;
            err_d        = 1'b0;
            done_d       = 1'b0;
            cpu_enable_d = 1'b0;
`ifdef IMEM_LOADER_BASE_ADDR_EN
            state_d      = ST_BASE;
`else
            addr_d       = '0;
            state_d      = ST_HI;
`endif
         end
         ST_BASE: if (xfer) begin
            addr_d  = ADDR_W'(bus.rx_data);
            chk_acc = 1'b1;
            state_d = ST_HI;
         end
         ST_HI: if (xfer) begin
            hi_d    = bus.rx_data;
            chk_acc = 1'b1;
            state_d = ST_LO;
         end
         ST_LO: if (xfer) begin
            chk_acc   = 1'b1;
            i_we_d    = 1'b1;
            i_addr_d  = addr_q;
            i_wdata_d = DATA_W'({hi_q, bus.rx_data});
            addr_d    = addr_q + 1'b1;
            count_d   = count_q - 1'b1;
            state_d   = (count_q == 9'd1) ? ST_CHK : ST_HI;
         end
         ST_CHK: if (xfer) begin
            if (chk_match) begin
               cpu_enable_d = 1'b1;
               done_d       = 1'b1;
               dly_d        = 4'd0;
               state_d      = ST_ARM;
            end else begin
               err_d   = 1'b1;
               state_d = ST_ERR;
            end
         end
         // ARM lasts START_DLY cycles; cpu_start is raised on entry to START.
         ST_ARM: begin
            if (dly_q == 4'(START_DLY - 1)) begin
               cpu_start_d = 1'b1;
               state_d     = ST_START;
            end else begin
               dly_d = dly_q + 4'd1;
            end
         end
         ST_START: state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
      busy_d = st_busy(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         addr_q       <= '0;
         hi_q         <= '0;
         dly_q        <= '0;
         i_we_q       <= 1'b0;
         i_addr_q     <= '0;
         i_wdata_q    <= '0;
         cpu_enable_q <= 1'b0;
         cpu_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         addr_q       <= addr_d;
         hi_q         <= hi_d;
         dly_q        <= dly_d;
         i_we_q       <= i_we_d;
         i_addr_q     <= i_addr_d;
         i_wdata_q    <= i_wdata_d;
         cpu_enable_q <= cpu_enable_d;
         cpu_start_q  <= cpu_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign bus.rx_ready = rx_rdy;
   assign bus.i_we     = i_we_q;
   assign bus.i_addr   = i_addr_q;
   assign bus.i_wdata  = i_wdata_q;
   assign cpu_enable   = cpu_enable_q;
   assign cpu_start    = cpu_start_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum errors, 256-word wrap, stalls, mid-frame reset.
module tb_imem_loader;
   localparam int START_DLY = 1;

   logic clk = 1'b0;
   logic rst;
   logic cpu_enable, cpu_start, busy, done, err;

   imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   imem_loader #(.ADDR_W(8), .DATA_W(16), .SYNC_BYTE(8'hA5), .START_DLY(START_DLY)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cpu_enable (cpu_enable),
      .cpu_start  (cpu_start),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cnt, start_cyc, en_cyc, rdy_low;
   logic en_prev = 1'b0;
   logic gap = 1'b0;
   logic [7:0]  wq_a [$];
   logic [15:0] wq_d [$];
   logic [15:0] fw [256];

   always @(negedge clk) begin
      cyc++;
      if (bus.i_we) begin
         wq_a.push_back(bus.i_addr);
         wq_d.push_back(bus.i_wdata);
      end
      if (cpu_start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (cpu_enable && !en_prev) en_cyc = cyc;
      en_prev = cpu_enable;
      if (!bus.rx_ready) rdy_low++;
   end

   task automatic clr_log();
      wq_a.delete();
      wq_d.delete();
      start_cnt = 0;
      rdy_low   = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      if (gap) @(negedge clk);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      t = 0;
      while (!bus.rx_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout byte %h never accepted", b);
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   // Checksum is computed by the bench from the frame contents; flip corrupts it.
   task automatic send_frame(input logic [7:0] cnt, input logic [7:0] base, input int n,
                             input logic [7:0] flip);
      logic [7:0] c;
      c = cnt;
      send_byte(8'hA5);
      send_byte(cnt);
`ifdef IMEM_LOADER_BASE_ADDR_EN
      c ^= base;
      send_byte(base);
`endif
      for (int i = 0; i < n; i++) begin
         c ^= fw[i][15:8] ^ fw[i][7:0];
         send_byte(fw[i][15:8]);
         send_byte(fw[i][7:0]);
      end
      send_byte(c ^ flip);
   endtask

   task automatic check_basic_writes(input string tag);
      checks++;
      if (wq_a.size() != 2 || wq_a[0] !== 8'h00 || wq_d[0] !== 16'h1234 ||
          wq_a[1] !== 8'h01 || wq_d[1] !== 16'hABCD)
         begin
            errors++;
            $display("FAIL %s_writes got n=%0d %h:%h %h:%h exp n=2 00:1234 01:ABCD", tag,
                     wq_a.size(), wq_a[0], wq_d[0], wq_a[1], wq_d[1]);
         end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      idle(3);
      checks++;
      if ({bus.i_we, bus.i_addr, bus.i_wdata, cpu_enable, cpu_start, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got we=%b a=%h d=%h en=%b st=%b busy=%b done=%b err=%b exp all 0",
                  bus.i_we, bus.i_addr, bus.i_wdata, cpu_enable, cpu_start, busy, done, err);
      end
      rst = 1'b0;
      idle(1);
      checks++;
      if (bus.rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", bus.rx_ready);
      end
   endtask

   task automatic test_basic();
      clr_log();
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      send_frame(8'h02, 8'h00, 2, 8'h00);
      checks++;
      if ({cpu_enable, done, busy} !== 3'b111) begin
         errors++;
         $display("FAIL basic_arm got en=%b done=%b busy=%b exp 1 1 1", cpu_enable, done, busy);
      end
      idle(6);
      check_basic_writes("basic");
      checks++;
      if (start_cnt !== 1 || (start_cyc - en_cyc) !== START_DLY) begin
         errors++;
         $display("FAIL basic_start got pulses=%0d delay=%0d exp 1 %0d", start_cnt,
                  start_cyc - en_cyc, START_DLY);
      end
      checks++;
      if ({cpu_enable, done, err, busy} !== 4'b1100) begin
         errors++;
         $display("FAIL basic_final got en=%b done=%b err=%b busy=%b exp 1 1 0 0",
                  cpu_enable, done, err, busy);
      end
   endtask

   task automatic test_bad_chk();
      clr_log();
      send_frame(8'h02, 8'h00, 2, 8'h01);
      idle(5);
      checks++;
      if ({err, cpu_enable, done, busy} !== 4'b1000 || start_cnt !== 0) begin
         errors++;
         $display("FAIL badchk_state got err=%b en=%b done=%b busy=%b pulses=%0d exp 1 0 0 0 0",
                  err, cpu_enable, done, busy, start_cnt);
      end
      check_basic_writes("badchk");
      clr_log();
      send_frame(8'h02, 8'h00, 2, 8'h00);
      idle(5);
      checks++;
      if ({err, cpu_enable, done} !== 3'b011 || start_cnt !== 1) begin
         errors++;
         $display("FAIL badchk_recover got err=%b en=%b done=%b pulses=%0d exp 0 1 1 1",
                  err, cpu_enable, done, start_cnt);
      end
   endtask

   task automatic test_cnt256();
      int nbad;
      clr_log();
      for (int i = 0; i < 256; i++) fw[i] = 16'(16'h0100 + i);
      send_frame(8'h00, 8'h00, 256, 8'h00);
      idle(5);
      checks++;
      if (wq_a.size() != 256) begin
         errors++;
         $display("FAIL cnt256_nwr got %0d exp 256", wq_a.size());
      end
      nbad = 0;
      for (int i = 0; i < wq_a.size(); i++)
         if (wq_a[i] !== 8'(i) || wq_d[i] !== 16'(16'h0100 + i)) nbad++;
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL cnt256_data got %0d bad writes exp 0", nbad);
      end
      checks++;
      if ({done, err, bus.i_addr} !== {2'b10, 8'hFF}) begin
         errors++;
         $display("FAIL cnt256_done got done=%b err=%b last_addr=%h exp 1 0 ff", done, err, bus.i_addr);
      end
   endtask

   task automatic test_gaps();
      clr_log();
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      gap = 1'b1;
      send_frame(8'h02, 8'h00, 2, 8'h00);
      gap = 1'b0;
      idle(6);
      check_basic_writes("gaps");
      checks++;
      if (rdy_low !== START_DLY + 1 || start_cnt !== 1 || done !== 1'b1) begin
         errors++;
         $display("FAIL gaps_handoff got ready_low=%0d pulses=%0d done=%b exp %0d 1 1",
                  rdy_low, start_cnt, done, START_DLY + 1);
      end
   endtask

   task automatic test_rst_mid();
      clr_log();
      send_byte(8'hA5);
      send_byte(8'h02);
`ifdef IMEM_LOADER_BASE_ADDR_EN
      send_byte(8'h00);
`endif
      send_byte(8'h12);
      send_byte(8'h34);
      @(negedge clk);
      rst = 1'b1;
      bus.rx_data  = 8'hAB;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      checks++;
      if ({bus.i_we, bus.i_addr, bus.i_wdata, cpu_enable, cpu_start, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got we=%b a=%h d=%h en=%b st=%b busy=%b done=%b err=%b exp all 0",
                  bus.i_we, bus.i_addr, bus.i_wdata, cpu_enable, cpu_start, busy, done, err);
      end
      rst = 1'b0;
      checks++;
      if (wq_a.size() != 1 || wq_a[0] !== 8'h00 || wq_d[0] !== 16'h1234) begin
         errors++;
         $display("FAIL rstmid_partial got n=%0d %h:%h exp n=1 00:1234", wq_a.size(), wq_a[0], wq_d[0]);
      end
      clr_log();
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      send_frame(8'h02, 8'h00, 2, 8'h00);
      idle(5);
      check_basic_writes("rstmid_reload");
      checks++;
      if ({done, cpu_enable} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid_done got done=%b en=%b exp 1 1", done, cpu_enable);
      end
   endtask

`ifdef IMEM_LOADER_BASE_ADDR_EN
   task automatic test_base();
      clr_log();
      fw[0] = 16'h0001;
      send_frame(8'h01, 8'hFE, 1, 8'h00);
      idle(5);
      checks++;
      if (wq_a.size() != 1 || wq_a[0] !== 8'hFE || wq_d[0] !== 16'h0001 || done !== 1'b1) begin
         errors++;
         $display("FAIL base_write got n=%0d %h:%h done=%b exp n=1 fe:0001 1",
                  wq_a.size(), wq_a[0], wq_d[0], done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_bad_chk();
      test_cnt256();
      test_gaps();
      test_rst_mid();
`ifdef IMEM_LOADER_BASE_ADDR_EN
      test_base();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
